// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bundle between fetch_ctrl and imem.
// The fetch side drives req/addr; memory returns ack and data in the ack cycle.
interface fetch_ctrl_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;

  modport master (output imemReq, output imemAddr, input imemAck, input imemData);
  modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake and
// delivers each accepted word through a one-entry output register to decode.
// Branch/exception redirects flush the output and any in-flight fetch; a fetch
// still outstanding at redirect time is drained in KILL on its stale address.
// Optional feature macro: FETCH_PERF_EN adds fetchCount_o / killCount_o.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               branchEnable_i,
  input  logic [31:0]        branchAddr_i,
  input  logic               exceptionEnable_i,
  input  logic [31:0]        exceptionAddr_i,
  fetch_ctrl_if.master       imem,
  output logic [31:0]        pc_o,
  output logic               instValid_o,
  output logic [31:0]        inst_o,
  output logic [31:0]        instPc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetchCount_o,
  output logic [31:0]        killCount_o
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] killAddr_q, killAddr_d;
  logic        held_q, held_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instPc_q, instPc_d;

  logic        redir, slotFree, req, ackReq, accept, discard;
  logic [31:0] tgt;

  // Exception wins over branch when both fire together.
  assign redir    = exceptionEnable_i | branchEnable_i;
  assign tgt      = exceptionEnable_i ? exceptionAddr_i : branchAddr_i;
  assign slotFree = !valid_q || !stall_i;
  // A request already on the bus (held_q) stays up even if decode stalls.
  assign req      = (state_q == S_KILL) ||
                    ((state_q == S_REQ) && (slotFree || held_q));
  assign ackReq   = req && imem.imemAck;
  // An ack while the slot is stalled-full is not taken; the request stays held.
  assign accept   = (state_q == S_REQ) && ackReq && slotFree && !redir;
  assign discard  = ackReq && ((state_q == S_KILL) || redir);

  assign imem.imemReq  = req;
  assign imem.imemAddr = (state_q == S_KILL) ? killAddr_q : pc_q;
  assign pc_o          = pc_q;
  assign instValid_o   = valid_q;
  assign inst_o        = inst_q;
  assign instPc_o      = instPc_q;

  // Next-state: sequencing, redirect handling and output-slot management.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    killAddr_d = killAddr_q;
    held_d     = 1'b0;
    valid_d    = valid_q;
    inst_d     = inst_q;
    instPc_d   = instPc_q;
    if (redir) begin
      pc_d    = tgt;
      valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redir) begin
          if (req && !imem.imemAck) begin
            state_d    = S_KILL;
            killAddr_d = pc_q;
          end
        end else if (accept) begin
          inst_d   = imem.imemData;
          instPc_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_STEP;
        end else begin
          held_d = req;
          if (valid_q && !stall_i) valid_d = 1'b0;
        end
      end
      S_KILL: if (imem.imemAck) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      killAddr_q <= 32'h0;
      held_q     <= 1'b0;
      valid_q    <= 1'b0;
      inst_q     <= 32'h0;
      instPc_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      killAddr_q <= killAddr_d;
      held_q     <= held_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      instPc_q   <= instPc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetchCnt_q, killCnt_q;
  assign fetchCount_o = fetchCnt_q;
  assign killCount_o  = killCnt_q;

  // Counters of written and discarded acks; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchCnt_q <= 32'h0;
      killCnt_q  <= 32'h0;
    end else begin
      if (accept)  fetchCnt_q <= fetchCnt_q + 32'd1;
      if (discard) killCnt_q  <= killCnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl. The reference model is the
// program stream: decode must see consecutive words from the last redirect
// target (or RESET_PC), each carrying memf(address), with nothing lost or
// duplicated. Protocol and stall-hold rules are checked every cycle.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall, br, exc;
  logic [31:0] brA, excA;
  logic [31:0] pc, inst, instPc;
  logic        valid;
  fetch_ctrl_if bus ();
`ifdef FETCH_PERF_EN
  logic [31:0] fcnt, kcnt;
`endif

  fetch_ctrl #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .branchEnable_i(br), .branchAddr_i(brA),
    .exceptionEnable_i(exc), .exceptionAddr_i(excA),
    .imem(bus.master),
    .pc_o(pc), .instValid_o(valid), .inst_o(inst), .instPc_o(instPc)
`ifdef FETCH_PERF_EN
    , .fetchCount_o(fcnt), .killCount_o(kcnt)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
  endfunction
  assign bus.imemData = memf(bus.imemAddr);

  int checks = 0, failures = 0, consumed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tail;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(tail);
      tail = tail + 32'd4;
    end
  endtask

  task automatic redirect_to(input logic [31:0] t);
    exp_q.delete();
    tail = t;
    refill();
  endtask

  // Monitor: protocol rules plus in-order comparison of consumed instructions.
  logic        p_req, p_ack, p_valid, p_stall, p_redir;
  logic [31:0] p_addr, p_inst, p_instPc, p_pc;
  always @(negedge clk) begin
    if (!mon_en) begin
      p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_stall = 1'b0; p_redir = 1'b0;
    end else begin
      if (p_req && !p_ack) begin
        chk("req_hold", {31'b0, bus.imemReq}, 32'd1);
        chk("addr_hold", bus.imemAddr, p_addr);
      end
      if (p_valid && p_stall && !p_redir) begin
        chk("stall_valid", {31'b0, valid}, 32'd1);
        chk("stall_inst", inst, p_inst);
        chk("stall_instPc", instPc, p_instPc);
        chk("stall_pc", pc, p_pc);
      end
      if (valid && !stall && !br && !exc) begin
        logic [31:0] e;
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instPc", instPc, e);
          chk("sb_inst", inst, memf(e));
          consumed++;
          refill();
        end
      end
      p_req = bus.imemReq; p_ack = bus.imemAck; p_addr = bus.imemAddr;
      p_valid = valid; p_stall = stall; p_redir = br | exc;
      p_inst = inst; p_instPc = instPc; p_pc = pc;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_req"}, {31'b0, bus.imemReq}, 32'd0);
    chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_instPc"}, instPc, 32'h0);
`ifdef FETCH_PERF_EN
    chk({tag, "_fcnt"}, fcnt, 32'h0);
    chk({tag, "_kcnt"}, kcnt, 32'h0);
`endif
  endtask

  task automatic random_run(input int n);
    logic [31:0] pend;
    bit has_pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (has_pend) chk("redir_pc", pc, pend);
      has_pend = 1'b0;
      br = 1'b0; exc = 1'b0;
      stall = ($urandom_range(0, 3) == 0) || (i % 97 > 90);
      bus.imemAck = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) begin
        int kind = $urandom_range(0, 2);
        brA  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        excA = $urandom & 32'hFFFF_FFFC;
        br  = (kind != 1);
        exc = (kind != 0);
        pend = exc ? excA : brA;
        has_pend = 1'b1;
        redirect_to(pend);
      end
    end
    @(posedge clk); #1;
    if (has_pend) chk("redir_pc", pc, pend);
    br = 1'b0; exc = 1'b0;
  endtask

  initial begin
    stall = 1'b0; br = 1'b0; exc = 1'b0; brA = 32'h0; excA = 32'h0;
    bus.imemAck = 1'b0;
    #1 rst = 1'b0;
    #2 check_reset("rst0");
    redirect_to(32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    bus.imemAck = 1'b1;
    // Back-to-back acks: PC steps by 4 each cycle, output trails by one fetch.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("seq_pc", pc, 32'(4 * i));
      if (i >= 1) begin
        chk("seq_valid", {31'b0, valid}, 32'd1);
        chk("seq_instPc", instPc, 32'(4 * (i - 1)));
      end
    end
    // Directed priority: both redirects together pick the exception vector.
    br = 1'b1; brA = 32'h100; exc = 1'b1; excA = 32'h180;
    redirect_to(32'h180);
    @(posedge clk); #1;
    chk("prio_pc", pc, 32'h180);
    chk("prio_valid", {31'b0, valid}, 32'd0);
    br = 1'b0; exc = 1'b0;
    random_run(3000);
    // Hold off acks so a request is waiting, then reset asynchronously mid-cycle.
    bus.imemAck = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst = 1'b0;
    #1 check_reset("rst_mid");
    @(posedge clk); #1;
    rst = 1'b1;
    redirect_to(32'h0);
    mon_en = 1'b1;
    random_run(1500);
    chk("progress", {31'b0, consumed > 1000}, 32'd1);
    mon_en = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
